// File: rtl/gf2m_pkg.sv
// Shared GF(2^M) constants, exponentiator state encoding and a polynomial
// sanity check evaluated at elaboration time.
package gf2m_pkg;

    localparam int         GF_M    = 6;
    localparam logic [6:0] GF_POLY = 7'h43;

    typedef enum logic [1:0] {
        IDLE,
        SQR,
        MUL
    } exp_state_t;

    // A usable reduction polynomial has degree exactly m and a nonzero constant term.
    function automatic bit poly_deg_ok(input int m, input logic [32:0] poly);
        return (poly[m] == 1'b1) && (poly[0] == 1'b1) && ((poly >> (m + 1)) == 33'd0);
    endfunction

endpackage

// File: rtl/gf2m_mul.sv
// Combinational GF(2^M) multiplier: carry-less product followed by reduction
// modulo POLY, one partial-product row and one reduction row per bit.
module gf2m_mul
    import gf2m_pkg::*;
#(
    parameter int         M    = GF_M,
    parameter logic [M:0] POLY = GF_POLY
) (
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic [M-1:0] p
);

    localparam int            PW       = 2 * M - 1;
    localparam logic [PW-1:0] POLY_EXT = PW'(POLY);

    logic [PW-1:0] a_ext;
    logic [PW-1:0] prod;

    assign a_ext = PW'(a);

    always_comb begin
        prod = '0;
        for (int i = 0; i < M; i++) begin
            if (b[i]) begin
                prod = prod ^ (a_ext << i);
            end
        end
        // Clear the high bits from the top down so each step only touches lower ones.
        for (int i = PW - 1; i >= M; i--) begin
            if (prod[i]) begin
                prod = prod ^ (POLY_EXT << (i - M));
            end
        end
    end

    assign p = prod[M-1:0];

endmodule

// File: rtl/gf2m_exp_sqm.sv
// GF(2^M) exponentiator, ex = base^power, MSB-first square-and-multiply with a
// fixed 2*E_W cycle latency and a single shared field multiplier.
module gf2m_exp_sqm
    import gf2m_pkg::*;
#(
    parameter int         M    = GF_M,
    parameter logic [M:0] POLY = GF_POLY,
    parameter int         E_W  = M
) (
    input  logic           clk,
    input  logic           resetN,
    input  logic           start,
    input  logic [M-1:0]   base,
    input  logic [E_W-1:0] power,
    output logic           busy,
    output logic [M-1:0]   ex,
    output logic           ready_flag
);

    localparam int IDX_W = (E_W > 1) ? $clog2(E_W) : 1;

    if (!poly_deg_ok(M, 33'(POLY)) || M < 2 || M > 16 || E_W < 1 || E_W > 32) begin : g_bad_params
        $error("gf2m_exp_sqm: illegal M/E_W or POLY lacks the x^M or constant term");
    end

    exp_state_t     state;
    logic [M-1:0]   acc;
    logic [M-1:0]   base_q;
    logic [E_W-1:0] pow_q;
    logic [IDX_W-1:0] idx;
    logic [M-1:0]   mul_b;
    logic [M-1:0]   prod;
    logic [M-1:0]   mul_res;

    // Squaring and the conditional multiply never overlap, so one multiplier serves both.
    assign mul_b   = (state == SQR) ? acc : base_q;
    assign mul_res = pow_q[idx] ? prod : acc;

    gf2m_mul #(
        .M    (M),
        .POLY (POLY)
    ) u_mul (
        .a (acc),
        .b (mul_b),
        .p (prod)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            busy       <= 1'b0;
            ready_flag <= 1'b0;
            ex         <= '0;
            acc        <= '0;
            base_q     <= '0;
            pow_q      <= '0;
            idx        <= '0;
        end else begin
            ready_flag <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q <= base;
                        pow_q  <= power;
                        acc    <= M'(1);
                        idx    <= IDX_W'(E_W - 1);
                        state  <= SQR;
                        busy   <= 1'b1;
                    end
                end
                SQR: begin
                    acc   <= prod;
                    state <= MUL;
                end
                MUL: begin
                    acc <= mul_res;
                    if (idx == '0) begin
                        ex         <= mul_res;
                        ready_flag <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        idx   <= idx - IDX_W'(1);
                        state <= SQR;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf2m_exp_sqm.sv
// Scoreboard bench for gf2m_exp_sqm: a GF(2^6) default instance and a
// GF(2^8) instance, checked on result value and completion cycle.
module tb_gf2m_exp_sqm;

    typedef struct {
        logic [7:0] ex;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetN;
    logic       start6, start8;
    logic [5:0] base6, power6;
    logic [7:0] base8, power8;
    logic       busy6, busy8, ready6, ready8;
    logic [5:0] ex6;
    logic [7:0] ex8;

    int   cyc = 0;
    int   assertions = 0;
    int   failures = 0;
    exp_t q6[$];
    exp_t q8[$];
    exp_t e6, e8;

    gf2m_exp_sqm dut6 (
        .clk        (clk),
        .resetN     (resetN),
        .start      (start6),
        .base       (base6),
        .power      (power6),
        .busy       (busy6),
        .ex         (ex6),
        .ready_flag (ready6)
    );

    gf2m_exp_sqm #(.M(8), .POLY(9'h11D), .E_W(8)) dut8 (
        .clk        (clk),
        .resetN     (resetN),
        .start      (start8),
        .base       (base8),
        .power      (power8),
        .busy       (busy8),
        .ex         (ex8),
        .ready_flag (ready8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // xtime-based reference multiply in GF(2^8) modulo x^8+x^4+x^3+x^2+1
    function automatic logic [7:0] ref_mul8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
        end
        return r;
    endfunction

    function automatic logic [7:0] ref_pow8(input logic [7:0] b, input logic [7:0] p);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < int'(p); i++) r = ref_mul8(r, b);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        assertions++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic applyStimulus(input bit wide, input logic [7:0] b, input logic [7:0] p,
                                 input bit accept, input logic [7:0] exp_ex);
        exp_t e;
        e.ex  = exp_ex;
        e.due = cyc + 1 + (wide ? 16 : 12);
        if (accept) begin
            if (wide) q8.push_back(e);
            else      q6.push_back(e);
        end
        if (wide) begin
            start8 = 1'b1; base8 = b; power8 = p;
        end else begin
            start6 = 1'b1; base6 = b[5:0]; power6 = p[5:0];
        end
        @(negedge clk);
        start6 = 1'b0; start8 = 1'b0;
        base6 = 6'h3F; power6 = 6'h3F;
        base8 = 8'hFF; power8 = 8'hFF;
    endtask

    task automatic waitReady(input bit wide);
        int n = 0;
        while (!(wide ? ready8 : ready6) && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            assertions++;
            failures++;
            $display("[TB] FAIL ready_timeout wide=%0d got no ready_flag expected one within 64 cycles", wide);
        end
    endtask

    always @(negedge clk) begin
        if (ready6) begin
            assertions++;
            if (q6.size() == 0) begin
                failures++;
                $display("[TB] FAIL dut6_unexpected_ready got ex=%h expected no completion (cycle %0d)", ex6, cyc);
            end else begin
                e6 = q6.pop_front();
                if (ex6 !== e6.ex[5:0] || cyc != e6.due) begin
                    failures++;
                    $display("[TB] FAIL dut6_result got ex=%h at cycle %0d expected %h at cycle %0d",
                             ex6, cyc, e6.ex[5:0], e6.due);
                end
            end
        end
        if (ready8) begin
            assertions++;
            if (q8.size() == 0) begin
                failures++;
                $display("[TB] FAIL dut8_unexpected_ready got ex=%h expected no completion (cycle %0d)", ex8, cyc);
            end else begin
                e8 = q8.pop_front();
                if (ex8 !== e8.ex || cyc != e8.due) begin
                    failures++;
                    $display("[TB] FAIL dut8_result got ex=%h at cycle %0d expected %h at cycle %0d",
                             ex8, cyc, e8.ex, e8.due);
                end
            end
        end
    end

    initial begin
        logic [7:0] rb, rp;
        resetN = 1'b0;
        start6 = 1'b0; base6 = '0; power6 = '0;
        start8 = 1'b0; base8 = '0; power8 = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 32'(busy6), 32'd0);
        checkOutput("reset_ex", 32'(ex6), 32'd0);
        checkOutput("reset_ready", 32'(ready6), 32'd0);
        resetN = 1'b1;
        @(negedge clk);

        $display("[TB] directed GF(2^6) vectors");
        applyStimulus(1'b0, 8'h02, 8'd6, 1'b1, 8'h03);
        checkOutput("busy_after_start", 32'(busy6), 32'd1);
        repeat (10) @(negedge clk);
        checkOutput("busy_before_ready", 32'(busy6), 32'd1);
        waitReady(1'b0);
        checkOutput("busy_at_ready", 32'(busy6), 32'd0);
        @(negedge clk);
        checkOutput("ready_one_cycle", 32'(ready6), 32'd0);
        checkOutput("ex_held", 32'(ex6), 32'h03);

        applyStimulus(1'b0, 8'h02, 8'd7,  1'b1, 8'h06); waitReady(1'b0);
        applyStimulus(1'b0, 8'h03, 8'd2,  1'b1, 8'h05); waitReady(1'b0);
        applyStimulus(1'b0, 8'h02, 8'd63, 1'b1, 8'h01); waitReady(1'b0);
        applyStimulus(1'b0, 8'h00, 8'd0,  1'b1, 8'h01); waitReady(1'b0);
        applyStimulus(1'b0, 8'h00, 8'd5,  1'b1, 8'h00); waitReady(1'b0);
        applyStimulus(1'b0, 8'h2A, 8'd0,  1'b1, 8'h01); waitReady(1'b0);
        applyStimulus(1'b0, 8'h01, 8'd45, 1'b1, 8'h01); waitReady(1'b0);

        $display("[TB] start while busy, then start in the ready cycle");
        applyStimulus(1'b0, 8'h02, 8'd6, 1'b1, 8'h03);
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 8'h03, 8'd2, 1'b0, 8'h00);
        waitReady(1'b0);
        applyStimulus(1'b0, 8'h03, 8'd2, 1'b1, 8'h05);
        waitReady(1'b0);
        @(negedge clk);

        $display("[TB] reset in mid-operation");
        applyStimulus(1'b0, 8'h02, 8'd7, 1'b0, 8'h00);
        repeat (4) @(negedge clk);
        resetN = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy6), 32'd0);
        checkOutput("abort_ex", 32'(ex6), 32'd0);
        checkOutput("abort_ready", 32'(ready6), 32'd0);
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("abort_ex_after", 32'(ex6), 32'd0);
        applyStimulus(1'b0, 8'h02, 8'd7, 1'b1, 8'h06);
        waitReady(1'b0);
        @(negedge clk);

        $display("[TB] GF(2^8) directed and random vectors");
        applyStimulus(1'b1, 8'h02, 8'd8,   1'b1, 8'h1D); waitReady(1'b1);
        applyStimulus(1'b1, 8'h02, 8'd255, 1'b1, 8'h01); waitReady(1'b1);
        applyStimulus(1'b1, 8'h00, 8'd0,   1'b1, 8'h01); waitReady(1'b1);
        for (int i = 0; i < 1000; i++) begin
            rb = 8'($urandom_range(0, 255));
            rp = 8'($urandom_range(0, 255));
            applyStimulus(1'b1, rb, rp, 1'b1, ref_pow8(rb, rp));
            waitReady(1'b1);
        end
        repeat (20) @(negedge clk);
        checkOutput("q6_drained", 32'(q6.size()), 32'd0);
        checkOutput("q8_drained", 32'(q8.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/gf2m_exp_sqm.md
Name: gf2m_exp_sqm

Overview:
- Parametrised GF(2^M) exponentiation engine: ex = base^power, using MSB-first square-and-multiply.
- Successor to the fixed GF(2^6) linear-multiply exponentiator. Field width, reduction polynomial and exponent width are generics.
- Latency is fixed at 2*E_W cycles, independent of the power value. Adds busy/ready handshake and defined 0^0 semantics.
- Sits between the RS/BCH syndrome and locator logic and the field-arithmetic library.

Parameters:
- M, 6, field width in bits (legal 2..16).
- POLY, 7'h43, primitive polynomial including the x^M term, width M+1. Default is x^6+x+1.
- E_W, M, exponent width in bits (legal 1..32).

Ports:
- clk  input  1  system clock, rising edge
- resetN  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while idle (busy=0)
- base  input  M  field element; captured on the accepted start
- power  input  E_W  unsigned exponent; captured on the accepted start
- busy  output  1  high from the cycle after an accepted start until ready_flag
- ex  output  M  last completed result; held until the next completion
- ready_flag  output  1  one-cycle pulse; ex is valid in the same cycle

Behaviour:
- One clock (clk); reset is asynchronous and active-low (resetN).
- Reset values:
  - state=IDLE
  - busy=0, ready_flag=0, ex=0
  - internal acc, base_q, pow_q and bit index all 0
- States:
  - IDLE: if start, then base_q<=base, pow_q<=power, acc<=1, idx<=E_W-1, go to SQR. Otherwise stay.
  - SQR: acc<=acc*acc (field multiply), go to MUL.
  - MUL: acc<=pow_q[idx] ? acc*base_q : acc.
    - If idx==0: ex<=that value, ready_flag<=1, go to IDLE.
    - Otherwise: idx<=idx-1, go to SQR.
- Latency:
  - start sampled at edge k → ready_flag high after edge k+2*E_W.
  - Earliest next start sampled at edge k+2*E_W, i.e. back-to-back with the pulse. At default E_W=6 that is 12 cycles.
- busy = (state != IDLE). ready_flag is registered and high exactly one cycle.
- start while busy: ignored, with no queueing; the in-flight operands are unaffected.
- start in the same cycle as ready_flag: accepted, because the state is already IDLE in that cycle.
- Field arithmetic:
  - Product computed as a carry-less multiply, then reduction modulo POLY.
  - Result is always < 2^M. No exponent reduction mod 2^M-1 is needed: the loop is exact for any power.
- Edge cases:
  - power=0 → ex=1 for any base, including 0^0=1.
  - base=0 with power>0 → ex=0.
  - base=1 → ex=1.
- Reset mid-operation: aborts immediately. No ready_flag is produced, and ex returns to 0.
- Inputs base/power may change freely after the accepted start.

Decomposition:
- Package gf2m_pkg holds:
  - default constants GF_M=6, GF_POLY=7'h43;
  - typedef enum logic[1:0] {IDLE, SQR, MUL} exp_state_t;
  - a function poly_deg check used for elaboration-time assertions (POLY[M]==1, POLY[0]==1).
- One sub-module: gf2m_mul, purely combinational, parameters M and POLY, ports a, b, p.
- A single instance is shared between SQR and MUL via an operand mux: a=acc; b=acc in SQR, base_q in MUL.

Test Plan:
- M=6, base=6'h02, power=6'd6 → ex=6'h03, ready_flag exactly 12 cycles after start; busy high for 12 cycles.
- M=6, base=6'h02, power=6'd7 → ex=6'h06. base=6'h03, power=6'd2 → ex=6'h05. base=6'h02, power=6'd63 → ex=6'h01.
- Edge operands, each with the same 12-cycle latency:
  - base=0, power=0 → ex=1.
  - base=0, power=5 → ex=0.
  - base=6'h2A, power=0 → ex=1.
- Start at cycle 0 (2^6); a second start with base=3, power=2 is pulsed at cycle 4 → second start ignored, ex=6'h03.
  - A start asserted in the ready_flag cycle is accepted, giving 6'h05 twelve cycles later.
- Deassert resetN at cycle 5 of an operation → busy=0, ex=0, no ready_flag.
  - After release, a new start (2^7) completes normally with 6'h06.
- Re-elaborate with M=8, POLY=9'h11D, E_W=8: base=8'h02, power=8 → ex=8'h1D after 16 cycles. Random base/power vs. a reference model: 1000 vectors match.
